binary_gcd_unit: RTL and testbench

- Parametrised iterative GCD engine using the binary (Stein) algorithm: shifts and subtracts only, no divider. Successor to the fixed 16-bit subtractive GCD FSM.
- Adds generic WIDTH, a busy/done handshake, a held result, a zero-operand flag and an iteration counter.
- Sits as a slave compute unit behind a controller that issues start and waits for done.

---
 rtl/binary_gcd_unit.sv | 127 ++++++++++++
 tb/tb_binary_gcd_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/binary_gcd_unit.sv
// Iterative binary (Stein) GCD engine: shifts and subtracts only.
// Handshake: start accepted when idle, done pulses once, results held.
module binary_gcd_unit #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] gcd,
   output logic             zero_in,
   output logic [CNT_W-1:0] cycles
);

   localparam int KW = $clog2(WIDTH) + 1;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_STRIP   = 3'd1;
   localparam logic [2:0] S_REDUCE  = 3'd2;
   localparam logic [2:0] S_RESTORE = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [KW-1:0]    K_ONE   = {{(KW-1){1'b0}}, 1'b1};

   logic [2:0]       r_state;
   logic [WIDTH-1:0] r_x;
   logic [WIDTH-1:0] r_y;
   logic [WIDTH-1:0] r_r;
   logic [KW-1:0]    r_k;
   logic [WIDTH-1:0] r_gcd;
   logic             r_zero;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_cycles;

   logic             w_op_zero;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [WIDTH-1:0] w_dxy;
   logic [WIDTH-1:0] w_dyx;

   assign w_op_zero = (a == '0) || (b == '0);
   assign w_cnt_nxt = (r_cnt == '1) ? r_cnt : r_cnt + CNT_ONE;
   assign w_dxy     = r_x - r_y;
   assign w_dyx     = r_y - r_x;

   assign busy    = (r_state != S_IDLE);
   assign done    = (r_state == S_DONE);
   assign gcd     = r_gcd;
   assign zero_in = r_zero;
   assign cycles  = r_cycles;

   // Control FSM and datapath: strip common twos, reduce, then restore k.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_x      <= '0;
         r_y      <= '0;
         r_r      <= '0;
         r_k      <= '0;
         r_gcd    <= '0;
         r_zero   <= 1'b0;
         r_cnt    <= '0;
         r_cycles <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_x      <= a;
                  r_y      <= b;
                  r_k      <= '0;
                  r_cnt    <= '0;
                  r_cycles <= '0;
                  if (w_op_zero) begin
                     r_gcd   <= a | b;
                     r_zero  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_zero  <= 1'b0;
                     r_state <= S_STRIP;
                  end
               end
            end
            S_STRIP: begin
               r_cnt <= w_cnt_nxt;
               if (!r_x[0] && !r_y[0]) begin
                  r_x <= r_x >> 1;
                  r_y <= r_y >> 1;
                  r_k <= r_k + K_ONE;
               end else begin
                  r_state <= S_REDUCE;
               end
            end
            S_REDUCE: begin
               r_cnt <= w_cnt_nxt;
               if (r_x == r_y) begin
                  r_r     <= r_x;
                  r_state <= S_RESTORE;
               end else if (!r_x[0]) begin
                  r_x <= r_x >> 1;
               end else if (!r_y[0]) begin
                  r_y <= r_y >> 1;
               end else if (r_x > r_y) begin
                  r_x <= w_dxy >> 1;
               end else begin
                  r_y <= w_dyx >> 1;
               end
            end
            S_RESTORE: begin
               r_gcd    <= r_r << r_k;
               r_cycles <= r_cnt;
               r_state  <= S_DONE;
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_binary_gcd_unit.sv
// Directed bench for binary_gcd_unit: 16-bit vectors plus an 8-bit
// sweep against a Euclid reference with a step-count model.
module tb_binary_gcd_unit;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic        start16 = 1'b0;
   logic [15:0] a16 = '0;
   logic [15:0] b16 = '0;
   logic        busy16;
   logic        done16;
   logic [15:0] gcd16;
   logic        zero16;
   logic [7:0]  cyc16;

   logic        start8 = 1'b0;
   logic [7:0]  a8 = '0;
   logic [7:0]  b8 = '0;
   logic        busy8;
   logic        done8;
   logic [7:0]  gcd8;
   logic        zero8;
   logic [3:0]  cyc8;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   binary_gcd_unit #(.WIDTH(16), .CNT_W(8)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
      .busy(busy16), .done(done16), .gcd(gcd16), .zero_in(zero16),
      .cycles(cyc16)
   );

   binary_gcd_unit #(.WIDTH(8), .CNT_W(4)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .gcd(gcd8), .zero_in(zero8),
      .cycles(cyc8)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int ref_gcd(input int x, input int y);
      int t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   function automatic int ref_steps(input int x, input int y);
      int c = 0;
      while ((x % 2 == 0) && (y % 2 == 0)) begin
         x = x / 2;
         y = y / 2;
         c++;
      end
      c++;
      while (x != y) begin
         if (x % 2 == 0) x = x / 2;
         else if (y % 2 == 0) y = y / 2;
         else if (x > y) x = (x - y) / 2;
         else y = (y - x) / 2;
         c++;
      end
      c++;
      return c;
   endfunction

   // Issue one request on the 16-bit unit; optionally fire stray starts
   // at cycle 2 and during the done cycle.
   task automatic run16(input logic [15:0] ta, input logic [15:0] tb_,
                        input bit inj, output int lat, output int nd);
      @(negedge clk);
      a16 = ta;
      b16 = tb_;
      start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      lat = 0;
      nd = 0;
      for (int n = 1; n <= 80; n++) begin
         if (done16) begin
            nd++;
            if (lat == 0) lat = n;
         end
         start16 = 1'b0;
         if (!busy16 && lat != 0) break;
         if (inj && (n == 2 || done16)) begin
            a16 = 16'd7;
            b16 = 16'd5;
            start16 = 1'b1;
         end
         @(negedge clk);
      end
      start16 = 1'b0;
   endtask

   task automatic run8(input logic [7:0] ta, input logic [7:0] tb_,
                       output int lat, output int nd);
      @(negedge clk);
      a8 = ta;
      b8 = tb_;
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      lat = 0;
      nd = 0;
      for (int n = 1; n <= 60; n++) begin
         if (done8) begin
            nd++;
            if (lat == 0) lat = n;
         end
         if (!busy8 && lat != 0) break;
         @(negedge clk);
      end
   endtask

   initial begin
      int lat;
      int nd;
      int eg;
      int es;
      int nsat;
      bit seen;

      #1;
      check("rst_busy", busy16, 0);
      check("rst_done", done16, 0);
      check("rst_gcd", gcd16, 0);
      check("rst_zero", zero16, 0);
      check("rst_cycles", cyc16, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      run16(16'd12, 16'd18, 1'b0, lat, nd);
      check("12_18_lat", lat, 7);
      check("12_18_ndone", nd, 1);
      check("12_18_gcd", gcd16, 6);
      check("12_18_cycles", cyc16, 5);
      check("12_18_zero", zero16, 0);
      @(negedge clk);
      check("12_18_hold", gcd16, 6);

      run16(16'd0, 16'd35, 1'b0, lat, nd);
      check("0_35_lat", lat, 1);
      check("0_35_gcd", gcd16, 35);
      check("0_35_zero", zero16, 1);
      check("0_35_cycles", cyc16, 0);

      run16(16'd0, 16'd0, 1'b0, lat, nd);
      check("0_0_gcd", gcd16, 0);
      check("0_0_zero", zero16, 1);

      run16(16'hFFFF, 16'hFFFF, 1'b0, lat, nd);
      check("max_max_gcd", gcd16, 65535);
      check("max_max_cycles", cyc16, 2);
      check("max_max_zero", zero16, 0);

      run16(16'hFFFF, 16'd1, 1'b0, lat, nd);
      check("max_1_gcd", gcd16, 1);
      check("max_1_cycles", cyc16, 17);
      check("max_1_lat", lat, 19);

      run16(16'd32768, 16'd16384, 1'b0, lat, nd);
      check("pow2_gcd", gcd16, 16384);
      check("pow2_cycles", cyc16, 17);

      run16(16'd48, 16'd18, 1'b1, lat, nd);
      check("busy_ign_gcd", gcd16, 6);
      check("busy_ign_ndone", nd, 1);
      @(negedge clk);
      check("busy_ign_idle", busy16, 0);
      @(negedge clk);
      check("busy_ign_idle2", busy16, 0);

      @(negedge clk);
      a16 = 16'd1071;
      b16 = 16'd462;
      start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done16) seen = 1'b1;
      end
      check("mid_busy", busy16, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_busy", busy16, 0);
      check("arst_done", done16, 0);
      check("arst_gcd", gcd16, 0);
      check("arst_zero", zero16, 0);
      check("arst_cycles", cyc16, 0);
      repeat (4) begin
         @(negedge clk);
         if (done16) seen = 1'b1;
      end
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (done16) seen = 1'b1;
      end
      check("arst_nodone", seen, 0);
      run16(16'd1071, 16'd462, 1'b0, lat, nd);
      check("1071_462_gcd", gcd16, 21);
      check("1071_462_ndone", nd, 1);

      nsat = 0;
      for (int i = 0; i < 1000; i++) begin
         logic [7:0] ra;
         logic [7:0] rb;
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         if (i == 0) begin ra = 8'd0; rb = 8'd0; end
         if (i == 1) begin ra = 8'd255; rb = 8'd1; end
         run8(ra, rb, lat, nd);
         eg = ref_gcd(int'(ra), int'(rb));
         if (ra == 0 || rb == 0) es = 0;
         else es = ref_steps(int'(ra), int'(rb));
         check("sw_gcd", gcd8, eg);
         check("sw_ndone", nd, 1);
         check("sw_lat_le27", (lat >= 1 && lat <= 27), 1);
         check("sw_lat", lat, (es == 0) ? 1 : es + 2);
         check("sw_cycles", cyc8, (es > 15) ? 15 : es);
         if (es > 15) nsat++;
      end
      $display("8-bit sweep: %0d saturating requests", nsat);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
